// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - single-lane parking gate controller with free-space counter
module parking_gate_controller #(
  parameter logic [7:0] CAPACITY    = 8'd200,
  parameter logic [7:0] GATE_CYCLES = 8'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry,
  input  logic       exit,
  output logic [7:0] parking_capacity,
  output logic       entry_gate,
  output logic       exit_gate,
  output logic       entry_ack,
  output logic       exit_ack,
  output logic       entry_reject,
  output logic       exit_reject,
  output logic       full
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] timer;
  logic [7:0] timer_next;
  logic [7:0] capacity_next;
  logic       entry_ack_next;
  logic       exit_ack_next;
  logic       entry_reject_next;
  logic       exit_reject_next;
  logic       exit_accept;
  logic       timer_done;

  // An exit is only legal while at least one car is parked.
  assign exit_accept = exit && (parking_capacity < CAPACITY);
  assign timer_done  = (timer == (GATE_CYCLES - 8'd1));

  // Full is decoded straight from the registered free-space count.
  assign full = (parking_capacity == 8'd0);

  // Next-state, counter and pulse decisions; only IDLE looks at the requests.
  always_comb begin
    state_next        = state;
    timer_next        = timer;
    capacity_next     = parking_capacity;
    entry_ack_next    = 1'b0;
    exit_ack_next     = 1'b0;
    entry_reject_next = 1'b0;
    exit_reject_next  = 1'b0;
    case (state)
      IDLE: begin
        timer_next = 8'd0;
        if (exit_accept) begin
          // Exit wins; a simultaneous entry is left pending for the next IDLE cycle.
          state_next    = EXIT_OPEN;
          capacity_next = parking_capacity + 8'd1;
          exit_ack_next = 1'b1;
        end else begin
          if (exit) begin
            exit_reject_next = 1'b1;
          end
          if (entry) begin
            if (parking_capacity != 8'd0) begin
              state_next     = ENTRY_OPEN;
              capacity_next  = parking_capacity - 8'd1;
              entry_ack_next = 1'b1;
            end else begin
              entry_reject_next = 1'b1;
            end
          end
        end
      end
      ENTRY_OPEN, EXIT_OPEN: begin
        // Requests are ignored while a gate is open; the timer counts open cycles.
        if (timer_done) begin
          state_next = IDLE;
          timer_next = 8'd0;
        end else begin
          timer_next = timer + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = 8'd0;
      end
    endcase
  end

  // State, timer, free-space count and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      timer            <= 8'd0;
      parking_capacity <= CAPACITY;
      entry_gate       <= 1'b0;
      exit_gate        <= 1'b0;
      entry_ack        <= 1'b0;
      exit_ack         <= 1'b0;
      entry_reject     <= 1'b0;
      exit_reject      <= 1'b0;
    end else begin
      state            <= state_next;
      timer            <= timer_next;
      parking_capacity <= capacity_next;
      entry_gate       <= (state_next == ENTRY_OPEN);
      exit_gate        <= (state_next == EXIT_OPEN);
      entry_ack        <= entry_ack_next;
      exit_ack         <= exit_ack_next;
      entry_reject     <= entry_reject_next;
      exit_reject      <= exit_reject_next;
    end
  end

endmodule
